tx_piso: RTL and testbench
==========================

TX_PISO -- requirements
Module: tx_piso

Interface
REQ-001 SHALL have parameter FRAME_W, default 11, meaning the width of the padded parallel frame from the framer.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port baud_tick, input, 1, meaning a one-clk-wide enable at the bit rate.
REQ-005 SHALL have port send, input, 1, meaning a transmit request, level-sampled.
REQ-006 SHALL have port frame_in, input, FRAME_W, meaning the framer output, LSB is the start bit, padded with 1s.
REQ-007 SHALL have port parity_type, input, 2, with the framer encoding: 01 odd, 10 even, 00/11 none.
REQ-008 SHALL have ports data_length, input, 1 (0 = 7 bits, 1 = 8 bits) and stop_bits, input, 1 (0 = 1 bit, 1 = 2 bits).
REQ-009 SHALL have port data_tx, output, 1, meaning the serial line, idle high.
REQ-010 SHALL have ports active_flag, output, 1 (transmission in progress) and done_flag, output, 1 (one-clk end-of-frame pulse).

Function
REQ-011 SHALL implement states IDLE, ARMED, SHIFT.
REQ-012 In IDLE with send=1, SHALL latch frame_in, frame_len and go to ARMED on the same edge; baud_tick in that cycle SHALL be ignored.
REQ-013 SHALL compute frame_len = 1 + (data_length ? 8 : 7) + (parity_type in {01,10} ? 1 : 0) + (stop_bits ? 2 : 1), giving a 4-bit range of 9..12.
REQ-014 SHALL clamp frame_len to FRAME_W when the sum exceeds FRAME_W; the clamped bits are all 1s.
REQ-015 In ARMED on baud_tick, SHALL drive data_tx <= latched bit 0, set bit_cnt to 1 and go to SHIFT.
REQ-016 In SHIFT on baud_tick with bit_cnt < frame_len, SHALL drive data_tx <= latched bit[bit_cnt] and increment bit_cnt.
REQ-017 In SHIFT on baud_tick with bit_cnt == frame_len, SHALL drive data_tx <= 1, pulse done_flag for exactly one clk and return to IDLE. Every bit, including the last stop bit, is therefore held one full baud period.
REQ-018 Without baud_tick, SHALL hold data_tx and all state.
REQ-019 active_flag SHALL be 1 in ARMED and SHIFT, and 0 in IDLE, including the done_flag cycle.
REQ-020 SHALL ignore send outside IDLE; frame_in and configuration changes mid-frame SHALL NOT affect the frame in flight.
REQ-021 A send held high continuously SHALL start a new frame on the clk after the done_flag cycle.
REQ-022 The latched frame_in SHALL be sent unchanged, with no parity computation; an all-ones frame_in SHALL be shifted as normal, leaving the line high.
REQ-023 data_tx SHALL be driven directly from a flop, with no combinational path from any input.

Reset
REQ-024 rst=0 SHALL asynchronously force state=IDLE, data_tx=1, active_flag=0, done_flag=0, bit_cnt=0, and frame and length registers to all 1s and 0 respectively.
REQ-025 Reset asserted mid-frame SHALL abort it immediately with no done_flag; after release the block SHALL wait in IDLE for a new send.

Structure
REQ-026 uart_pkg SHALL hold the state enum, FRAME_W, the parity-type codes and the frame_len function shared with the framer.
REQ-027 The block SHALL be a single module with no sub-module; the baud generator remains external.

Verification
REQ-028 8N1 (parity_type=00, data_length=1, stop_bits=0), frame_in={2'b11,8'hA5,1'b0}, send pulsed -> at successive ticks data_tx = 0,1,0,1,0,0,1,0,1,1; at the 11th tick data_tx=1 and done_flag=1 for one clk.
REQ-029 7O2 (parity_type=01, data_length=0, stop_bits=1), frame_in=11'b11_1_1000001_0 -> 11 bits emitted LSB first; done_flag at the 12th tick; active_flag high from the send edge until that tick.
REQ-030 send and baud_tick in the same IDLE cycle -> latch only; start bit 0 appears at the next tick; send re-pulsed mid-frame -> no effect.
REQ-031 rst=0 asserted at the 5th bit of a frame -> data_tx=1 and active_flag=0 asynchronously, no done_flag; a new send after release transmits a full frame.
REQ-032 send held high across two frames with frame_in changed mid-frame -> the first frame is unaltered, the second starts the clk after done_flag, and the line shows no glitch below one baud period.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: serialiser state encoding, padded frame
// width, framer parity-type codes and the frame-length rule the framer also uses.
package uart_pkg;

   localparam int FRAME_W = 11;

   // Parity-type codes as produced by the framer; 00 and 11 both mean no parity.
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2
   } tx_state_t;

   // Bits on the line for one frame: start + data + optional parity + stop(s).
   // Range is 9..12, so four bits are enough.
   function automatic logic [3:0] frame_len(input logic [1:0] parity_type,
                                            input logic       data_length,
                                            input logic       stop_bits);
      logic [3:0] len;
      len = 4'd1
          + (data_length ? 4'd8 : 4'd7)
          + (((parity_type == PAR_ODD) || (parity_type == PAR_EVEN)) ? 4'd1 : 4'd0)
          + (stop_bits ? 4'd2 : 4'd1);
      return len;
   endfunction

endpackage

// File: rtl/tx_piso_if.sv
// Transmit bus between the framer/baud generator and the serialiser.
// Latency: none, wiring only.
// Backpressure: none; send is a level request honoured only while the serialiser is idle.
interface tx_piso_if #(
   parameter int FRAME_W = uart_pkg::FRAME_W
) ();
   import uart_pkg::*;

   logic               baud_tick;
   logic               send;
   logic [FRAME_W-1:0] frame_in;
   logic [1:0]         parity_type;
   logic               data_length;
   logic               stop_bits;
   logic               data_tx;
   logic               active_flag;
   logic               done_flag;

   // Framer / baud side.
   modport master (
      output baud_tick, send, frame_in, parity_type, data_length, stop_bits,
      input  data_tx, active_flag, done_flag
   );

   // Serialiser side.
   modport slave (
      input  baud_tick, send, frame_in, parity_type, data_length, stop_bits,
      output data_tx, active_flag, done_flag
   );

endinterface

// File: rtl/tx_piso.sv
// Parallel-in serial-out UART transmitter: shifts a latched padded frame LSB first.
// Latency: latch on send, first bit at the next baud_tick, done_flag one tick after the last bit.
// Backpressure: send is ignored while a frame is in flight; a held send restarts after done_flag.
module tx_piso #(
   parameter int FRAME_W = uart_pkg::FRAME_W
) (
   input  logic     clk,
   input  logic     rst,
   tx_piso_if.slave bus
);
   import uart_pkg::*;

   localparam int CNT_W = $clog2(FRAME_W + 1);

   tx_state_t          state;
   logic [FRAME_W-1:0] frame_q;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   bit_cnt;
   logic               tx_q;
   logic               active_q;
   logic               done_q;

   logic [3:0]         len_raw;
   logic [CNT_W-1:0]   len_in;

   assign len_raw = frame_len(bus.parity_type, bus.data_length, bus.stop_bits);

   // Clamp the length to the register width; the dropped positions are padding 1s,
   // which is exactly what the idle line shows after the frame anyway.
   always_comb begin
      len_in = CNT_W'(len_raw);
      if (int'(len_raw) > FRAME_W) begin
         len_in = CNT_W'(FRAME_W);
      end
   end

   // Frame sequencer: latch on send, emit one bit per baud_tick, flag the end of frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         frame_q  <= '1;
         len_q    <= '0;
         bit_cnt  <= '0;
         tx_q     <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               // A tick arriving with send is deliberately dropped: the start bit
               // must get a full baud period, so it waits for the next tick.
               if (bus.send) begin
                  frame_q  <= bus.frame_in;
                  len_q    <= len_in;
                  active_q <= 1'b1;
                  state    <= ARMED;
               end
            end
            ARMED: begin
               if (bus.baud_tick) begin
                  tx_q    <= frame_q[0];
                  bit_cnt <= CNT_W'(1);
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (bus.baud_tick) begin
                  if (bit_cnt < len_q) begin
                     tx_q    <= frame_q[bit_cnt];
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end else begin
                     // Last bit has had its full period; release the line.
                     tx_q     <= 1'b1;
                     bit_cnt  <= '0;
                     done_q   <= 1'b1;
                     active_q <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               tx_q     <= 1'b1;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_tx     = tx_q;
   assign bus.active_flag = active_q;
   assign bus.done_flag   = done_q;

endmodule

// File: tb/tb_tx_piso.sv
module tb_tx_piso;
   import uart_pkg::*;

   localparam int FW = FRAME_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   tx_piso_if #(.FRAME_W(FW)) bus ();

   tx_piso #(.FRAME_W(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Line length of a frame from the framer rules, limited to the frame register.
   function automatic int model_len(input logic [1:0] pt, input logic dl, input logic sb);
      int n;
      n = 1 + (dl ? 8 : 7) + (((pt == 2'b01) || (pt == 2'b10)) ? 1 : 0) + (sb ? 2 : 1);
      return (n > FW) ? FW : n;
   endfunction

   // Send one frame and check every tick against the expected bit list.
   // Between ticks the inputs are scrambled and send may be re-pulsed; none of it
   // may affect the frame in flight.
   task automatic send_frame(input logic [FW-1:0] frm, input logic [1:0] pt,
                             input logic dl, input logic sb, input bit tick_at_latch,
                             input bit keep_send, input int max_gap, input string tag);
      logic exp_q[$];
      int   len;
      int   gap;
      logic held;
      len = model_len(pt, dl, sb);
      for (int i = 0; i < len; i++) exp_q.push_back(frm[i]);

      bus.frame_in    = frm;
      bus.parity_type = pt;
      bus.data_length = dl;
      bus.stop_bits   = sb;
      bus.send        = 1'b1;
      bus.baud_tick   = tick_at_latch;
      step();
      bus.baud_tick = 1'b0;
      if (!keep_send) bus.send = 1'b0;
      chk({tag, " latch active"}, bus.active_flag, 1);
      chk({tag, " latch line"},   bus.data_tx,     1);
      chk({tag, " latch done"},   bus.done_flag,   0);

      for (int k = 0; k <= len; k++) begin
         gap = int'($urandom_range(0, max_gap));
         if (k == 0) held = 1'b1;
         else        held = exp_q[k-1];
         for (int g = 0; g < gap; g++) begin
            bus.frame_in    = FW'($urandom);
            bus.parity_type = 2'($urandom);
            bus.data_length = 1'($urandom);
            bus.stop_bits   = 1'($urandom);
            if (!keep_send) bus.send = 1'($urandom);
            step();
            if (!keep_send) bus.send = 1'b0;
            chk({tag, " hold line"},   bus.data_tx,     held);
            chk({tag, " hold active"}, bus.active_flag, 1);
            chk({tag, " hold done"},   bus.done_flag,   0);
         end
         bus.baud_tick = 1'b1;
         step();
         bus.baud_tick = 1'b0;
         if (k < len) begin
            chk($sformatf("%s bit%0d", tag, k),        bus.data_tx,     exp_q[k]);
            chk($sformatf("%s bit%0d active", tag, k), bus.active_flag, 1);
            chk($sformatf("%s bit%0d done", tag, k),   bus.done_flag,   0);
         end else begin
            chk({tag, " end line"},   bus.data_tx,     1);
            chk({tag, " end done"},   bus.done_flag,   1);
            chk({tag, " end active"}, bus.active_flag, 0);
         end
      end

      if (!keep_send) begin
         step();
         chk({tag, " post done"},   bus.done_flag,   0);
         chk({tag, " post active"}, bus.active_flag, 0);
         chk({tag, " post line"},   bus.data_tx,     1);
      end
   endtask

   initial begin
      logic [FW-1:0] frm;

      bus.baud_tick   = 1'b0;
      bus.send        = 1'b0;
      bus.frame_in    = '1;
      bus.parity_type = 2'b00;
      bus.data_length = 1'b1;
      bus.stop_bits   = 1'b0;

      // Reset state.
      #12;
      chk("reset line",   bus.data_tx,     1);
      chk("reset active", bus.active_flag, 0);
      chk("reset done",   bus.done_flag,   0);
      rst = 1'b1;
      step();
      bus.baud_tick = 1'b1;
      step();
      bus.baud_tick = 1'b0;
      chk("idle tick line",   bus.data_tx,     1);
      chk("idle tick active", bus.active_flag, 0);

      // 8N1 with 0xA5.
      frm = {2'b11, 8'hA5, 1'b0};
      send_frame(frm, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2, "8N1");

      // 7O2, tick arriving in the same cycle as send.
      frm = 11'b11_1_1000001_0;
      send_frame(frm, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2, "7O2");

      // Reset in the middle of a frame, on the 5th bit.
      frm = FW'($urandom);
      frm[0] = 1'b0;
      frm[4] = 1'b0;
      bus.frame_in    = frm;
      bus.parity_type = 2'b00;
      bus.data_length = 1'b1;
      bus.stop_bits   = 1'b0;
      bus.send        = 1'b1;
      step();
      bus.send = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.baud_tick = 1'b1;
         step();
         bus.baud_tick = 1'b0;
         chk($sformatf("abort bit%0d", k), bus.data_tx, frm[k]);
      end
      #2 rst = 1'b0;
      #1;
      chk("abort line",   bus.data_tx,     1);
      chk("abort active", bus.active_flag, 0);
      chk("abort done",   bus.done_flag,   0);
      for (int k = 0; k < 3; k++) begin
         bus.baud_tick = 1'b1;
         step();
         bus.baud_tick = 1'b0;
         chk("abort hold done", bus.done_flag, 0);
         chk("abort hold line", bus.data_tx,   1);
      end
      #2 rst = 1'b1;
      step();
      bus.baud_tick = 1'b1;
      step();
      bus.baud_tick = 1'b0;
      chk("after abort idle active", bus.active_flag, 0);
      chk("after abort idle line",   bus.data_tx,     1);
      send_frame(FW'($urandom), 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1, "after abort");

      // send held across two back-to-back frames.
      send_frame(FW'($urandom), 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2, "held A");
      send_frame(FW'($urandom), 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2, "held B");

      // Length clamp (8O2 sums to 12) and an all-ones frame.
      send_frame(FW'($urandom), 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1, "clamp 8O2");
      send_frame('1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1, "all ones");

      // Random frames and configurations.
      for (int r = 0; r < 6; r++) begin
         send_frame(FW'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'b0, 3, $sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
